branch_predictor: RTL and testbench

- Parametrised direct-mapped branch target buffer (BTB) plus a pattern history table (PHT) of saturating counters, with an optional gshare global history register (GHR).
- Drives the fetch-stage prediction bit and the predicted next PC for the 5-stage RV32I pipeline. This replaces the hard-wired "not taken" prediction.
- Lookup is combinational in IF.
- Training is synchronous from EX when a branch or jump resolves.
- Also keeps 32-bit lookup-hit and mispredict statistics counters.

---
 rtl/branch_predictor_pkg.sv | 35 +++
 rtl/branch_predictor_sat_counter_table.sv | 42 ++++
 rtl/branch_predictor.sv | 180 ++++++++++++++++++
 tb/tb_branch_predictor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module : branch_predictor_pkg
// Brief  : Shared constants and counter helper for the BTB/PHT predictor.
// Rev    : 1.0
// ============================================================================
package branch_predictor_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam int PC_W_DEF        = 12;
    localparam int BTB_ENTRIES_DEF = 16;
    localparam int CTR_W_MAX       = 3;
    localparam int IDX_W           = $clog2(BTB_ENTRIES_DEF);
    localparam int TAG_W           = PC_W_DEF - IDX_W - 2;

    // Counter is carried at the widest legal width; ctrW sets the clamp point.
    function automatic logic [CTR_W_MAX-1:0] ctr_sat_update(
        input logic [CTR_W_MAX-1:0] ctr,
        input logic                 inc,
        input int unsigned          ctrW
    );
        logic [CTR_W_MAX-1:0] maxVal;
        maxVal = CTR_W_MAX'((32'd1 << ctrW) - 32'd1);
        if (inc) begin
            ctr_sat_update = (ctr == maxVal) ? ctr : ctr + 1'b1;
        end else begin
            ctr_sat_update = (ctr == '0) ? ctr : ctr - 1'b1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_sat_counter_table.sv
`default_nettype none
// ============================================================================
// Module : sat_counter_table
// Brief  : PHT storage: two combinational read ports, one synchronous write
//          port and a single-cycle parallel clear.
// Rev    : 1.0
// ============================================================================
module sat_counter_table
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES   = 16,
    parameter int CTR_W     = 2,
    parameter int RESET_VAL = 1
) (
    input  logic                        CLK,
    input  logic                        RSTn,
    input  logic [$clog2(ENTRIES)-1:0]  i_rdIdxA,
    output logic [CTR_W-1:0]            o_rdCtrA,
    input  logic [$clog2(ENTRIES)-1:0]  i_rdIdxB,
    output logic [CTR_W-1:0]            o_rdCtrB,
    input  logic                        i_wrEn,
    input  logic [$clog2(ENTRIES)-1:0]  i_wrIdx,
    input  logic [CTR_W-1:0]            i_wrCtr
);

    logic [CTR_W-1:0] r_ctr [ENTRIES];

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int e = 0; e < ENTRIES; e++) begin
                r_ctr[e] <= CTR_W'(RESET_VAL);
            end
        end else if (i_wrEn) begin
            r_ctr[i_wrIdx] <= i_wrCtr;
        end
    end

    assign o_rdCtrA = r_ctr[i_rdIdxA];
    assign o_rdCtrB = r_ctr[i_rdIdxB];

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module : branch_predictor
// Brief  : Direct-mapped BTB plus PHT (optional gshare) giving the IF-stage
//          prediction; trained from EX, with hit/mispredict statistics.
// Rev    : 1.0
// ============================================================================
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter int CTR_W       = 2,
    parameter int GHR_W       = 0
) (
    input  logic                            CLK,
    input  logic                            RSTn,
    input  logic [PC_W-1:0]                 lk_pc,
    output logic                            lk_hit,
    output logic                            lk_taken,
    output logic [PC_W-1:0]                 lk_target,
    output logic [((GHR_W>0)?GHR_W:1)-1:0]  lk_ghr,
    input  logic                            upd_valid,
    input  logic [PC_W-1:0]                 upd_pc,
    input  logic                            upd_is_jump,
    input  logic                            upd_taken,
    input  logic [PC_W-1:0]                 upd_target,
    input  logic [((GHR_W>0)?GHR_W:1)-1:0]  upd_ghr,
    input  logic                            upd_mispred,
    output logic [31:0]                     stat_hits,
    output logic [31:0]                     stat_mispred
);

    localparam int c_idxW   = $clog2(BTB_ENTRIES);
    localparam int c_tagW   = PC_W - c_idxW - 2;
    localparam int c_ghrPw  = (GHR_W > 0) ? GHR_W : 1;
    localparam int c_weakT  = 1 << (CTR_W - 1);
    localparam int c_weakNt = c_weakT - 1;

    logic [BTB_ENTRIES-1:0] r_valid;
    logic [BTB_ENTRIES-1:0] r_isJump;
    logic [c_tagW-1:0]      r_tag    [BTB_ENTRIES];
    logic [PC_W-1:0]        r_target [BTB_ENTRIES];
    logic [31:0]            r_statHits;
    logic [31:0]            r_statMispred;

    logic [c_ghrPw-1:0] w_ghr;
    logic [c_idxW-1:0]  w_lkIdx;
    logic [c_idxW-1:0]  w_lkPhtIdx;
    logic [c_idxW-1:0]  w_updIdx;
    logic [c_idxW-1:0]  w_updPhtIdx;
    logic [c_tagW-1:0]  w_lkTag;
    logic [c_tagW-1:0]  w_updTag;
    logic [CTR_W-1:0]   w_lkCtr;
    logic [CTR_W-1:0]   w_updCtr;
    logic [CTR_W-1:0]   w_phtWrCtr;
    logic               w_phtWrEn;
    logic               w_updHit;
    logic               w_btbWr;
    logic               w_btbAlloc;
    logic               w_btbWrJump;
    logic               w_unusedPcLsb;

    assign w_lkIdx       = lk_pc[c_idxW+1:2];
    assign w_lkTag       = lk_pc[PC_W-1:c_idxW+2];
    assign w_updIdx      = upd_pc[c_idxW+1:2];
    assign w_updTag      = upd_pc[PC_W-1:c_idxW+2];
    assign w_unusedPcLsb = ^upd_pc[1:0];

    // The GHR is trained non-speculatively; training indexes with the
    // history the instruction saw at fetch, carried back as upd_ghr.
    generate
        if (GHR_W > 0) begin : g_ghr
            logic [GHR_W-1:0] r_ghr;
            always_ff @(posedge CLK) begin
                if (!RSTn) begin
                    r_ghr <= '0;
                end else if (upd_valid && !upd_is_jump) begin
                    r_ghr <= GHR_W'({r_ghr, upd_taken});
                end
            end
            assign w_ghr       = r_ghr;
            assign w_lkPhtIdx  = w_lkIdx ^ c_idxW'(r_ghr);
            assign w_updPhtIdx = w_updIdx ^ c_idxW'(upd_ghr);
        end else begin : g_noGhr
            logic w_unusedGhr;
            assign w_unusedGhr = ^upd_ghr;
            assign w_ghr       = '0;
            assign w_lkPhtIdx  = w_lkIdx;
            assign w_updPhtIdx = w_updIdx;
        end
    endgenerate

    sat_counter_table #(
        .ENTRIES   (BTB_ENTRIES),
        .CTR_W     (CTR_W),
        .RESET_VAL (c_weakNt)
    ) u_pht (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .i_rdIdxA (w_lkPhtIdx),
        .o_rdCtrA (w_lkCtr),
        .i_rdIdxB (w_updPhtIdx),
        .o_rdCtrB (w_updCtr),
        .i_wrEn   (w_phtWrEn),
        .i_wrIdx  (w_updPhtIdx),
        .i_wrCtr  (w_phtWrCtr)
    );

    assign lk_hit    = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag);
    assign lk_taken  = lk_hit && (r_isJump[w_lkIdx] || w_lkCtr[CTR_W-1]);
    assign lk_target = lk_taken ? r_target[w_lkIdx] : lk_pc + PC_W'(4);
    assign lk_ghr    = w_ghr;

    assign w_updHit  = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);

    always_comb begin
        w_phtWrEn   = 1'b0;
        w_phtWrCtr  = w_updCtr;
        w_btbWr     = 1'b0;
        w_btbAlloc  = 1'b0;
        w_btbWrJump = r_isJump[w_updIdx];
        if (upd_valid) begin
            if (w_updHit) begin
                w_btbWr     = upd_is_jump || upd_taken;
                w_btbWrJump = r_isJump[w_updIdx] || upd_is_jump;
                if (!upd_is_jump) begin
                    w_phtWrEn  = 1'b1;
                    w_phtWrCtr = CTR_W'(ctr_sat_update(CTR_W_MAX'(w_updCtr), upd_taken, CTR_W));
                end
            end else if (upd_taken) begin
                w_btbWr     = 1'b1;
                w_btbAlloc  = 1'b1;
                w_btbWrJump = upd_is_jump;
                if (!upd_is_jump) begin
                    w_phtWrEn  = 1'b1;
                    w_phtWrCtr = CTR_W'(c_weakT);
                end
            end else begin
                // Not-taken misses still train the counter toward not-taken.
                w_phtWrEn  = 1'b1;
                w_phtWrCtr = CTR_W'(ctr_sat_update(CTR_W_MAX'(w_updCtr), 1'b0, CTR_W));
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_valid  <= '0;
            r_isJump <= '0;
        end else if (w_btbWr) begin
            r_valid[w_updIdx]  <= 1'b1;
            r_isJump[w_updIdx] <= w_btbWrJump;
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTn && w_btbWr) begin
            r_target[w_updIdx] <= upd_target;
            if (w_btbAlloc) begin
                r_tag[w_updIdx] <= w_updTag;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_statHits    <= '0;
            r_statMispred <= '0;
        end else begin
            r_statHits    <= r_statHits + 32'(lk_hit);
            r_statMispred <= r_statMispred + 32'(upd_valid && upd_mispred);
        end
    end

    assign stat_hits    = r_statHits;
    assign stat_mispred = r_statMispred;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module : tb_branch_predictor
// Brief  : Directed and random checks of branch_predictor (plain and gshare).
// Rev    : 1.0
// ============================================================================
module tb_branch_predictor;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RSTn;
    logic [11:0] lk_pc, upd_pc, upd_target;
    logic        upd_valid, upd_is_jump, upd_taken, upd_mispred;
    logic        updGhrA;
    logic [3:0]  updGhrB;
    logic [1:0]  lkHit, lkTaken;
    logic [11:0] lkTarget [2];
    logic [31:0] statHits [2];
    logic [31:0] statMisp [2];
    logic        lkGhrA;
    logic [3:0]  lkGhrB;

    branch_predictor dutA (
        .CLK(CLK), .RSTn(RSTn), .lk_pc(lk_pc), .lk_hit(lkHit[0]), .lk_taken(lkTaken[0]),
        .lk_target(lkTarget[0]), .lk_ghr(lkGhrA), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_ghr(updGhrA), .upd_mispred(upd_mispred), .stat_hits(statHits[0]),
        .stat_mispred(statMisp[0])
    );

    branch_predictor #(.GHR_W(4)) dutB (
        .CLK(CLK), .RSTn(RSTn), .lk_pc(lk_pc), .lk_hit(lkHit[1]), .lk_taken(lkTaken[1]),
        .lk_target(lkTarget[1]), .lk_ghr(lkGhrB), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_ghr(updGhrB), .upd_mispred(upd_mispred), .stat_hits(statHits[1]),
        .stat_mispred(statMisp[1])
    );

    int          nChecks = 0;
    int          nErrors = 0;
    bit          chkEn   = 1'b0;

    // Reference model: instance 0 has no history, instance 1 a 4-bit GHR.
    int          gw [2] = '{0, 4};
    bit          mValid [2][16];
    bit          mJump  [2][16];
    int          mTag   [2][16];
    int          mTgt   [2][16];
    int          mCtr   [2][16];
    int          mGhr   [2];
    int unsigned mHits  [2];
    int unsigned mMisp  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mIdx(input int pc);
        return (pc >> 2) % 16;
    endfunction

    function automatic int mPht(input int k, input int idx, input int ghr);
        return (gw[k] == 0) ? idx : (idx ^ (ghr % 16));
    endfunction

    function automatic bit mHit(input int k, input int pc);
        return mValid[k][mIdx(pc)] && (mTag[k][mIdx(pc)] == (pc >> 6));
    endfunction

    function automatic bit mTaken(input int k, input int pc);
        int i = mIdx(pc);
        return mHit(k, pc) && (mJump[k][i] || mCtr[k][mPht(k, i, mGhr[k])] >= 2);
    endfunction

    function automatic int mTarget(input int k, input int pc);
        return mTaken(k, pc) ? mTgt[k][mIdx(pc)] : (pc + 4) % 4096;
    endfunction

    task automatic modelEdge(input int k, input int ghrIn);
        int i, p;
        bit h;
        if (!RSTn) begin
            for (int e = 0; e < 16; e++) begin
                mValid[k][e] = 0;
                mJump[k][e]  = 0;
                mCtr[k][e]   = 1;
            end
            mGhr[k] = 0; mHits[k] = 0; mMisp[k] = 0;
            return;
        end
        if (mHit(k, int'(lk_pc))) mHits[k]++;
        if (upd_valid && upd_mispred) mMisp[k]++;
        if (!upd_valid) return;
        i = mIdx(int'(upd_pc));
        p = mPht(k, i, ghrIn);
        h = mHit(k, int'(upd_pc));
        if (h) begin
            if (upd_is_jump) begin
                mTgt[k][i] = int'(upd_target);
                mJump[k][i] = 1;
            end else begin
                mCtr[k][p] = upd_taken ? ((mCtr[k][p] < 3) ? mCtr[k][p] + 1 : 3)
                                       : ((mCtr[k][p] > 0) ? mCtr[k][p] - 1 : 0);
                if (upd_taken) mTgt[k][i] = int'(upd_target);
            end
        end else if (upd_taken) begin
            mValid[k][i] = 1;
            mTag[k][i]   = int'(upd_pc) >> 6;
            mTgt[k][i]   = int'(upd_target);
            mJump[k][i]  = upd_is_jump;
            if (!upd_is_jump) mCtr[k][p] = 2;
        end else begin
            mCtr[k][p] = (mCtr[k][p] > 0) ? mCtr[k][p] - 1 : 0;
        end
        if (gw[k] > 0 && !upd_is_jump) mGhr[k] = ((mGhr[k] << 1) | int'(upd_taken)) % 16;
    endtask

    task automatic tick();
        @(negedge CLK);
        if (chkEn) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("lk_hit[%0d]", k), 32'(lkHit[k]), 32'(mHit(k, int'(lk_pc))));
                check($sformatf("lk_taken[%0d]", k), 32'(lkTaken[k]), 32'(mTaken(k, int'(lk_pc))));
                check($sformatf("lk_target[%0d]", k), 32'(lkTarget[k]), 32'(mTarget(k, int'(lk_pc))));
                check($sformatf("stat_hits[%0d]", k), statHits[k], mHits[k]);
                check($sformatf("stat_mispred[%0d]", k), statMisp[k], mMisp[k]);
            end
            check("lk_ghr[0]", 32'(lkGhrA), 32'd0);
            check("lk_ghr[1]", 32'(lkGhrB), 32'(mGhr[1]));
        end
        @(posedge CLK);
        modelEdge(0, 0);
        modelEdge(1, int'(updGhrB));
        #1;
    endtask

    task automatic look(input logic [11:0] pc);
        lk_pc     = pc;
        upd_valid = 1'b0;
        #1;
    endtask

    task automatic doUpd(input logic [11:0] pc, input logic j, input logic t,
                         input logic [11:0] tgt, input logic mp);
        upd_valid = 1'b1; upd_pc = pc; upd_is_jump = j; upd_taken = t;
        upd_target = tgt; upd_mispred = mp; updGhrB = lkGhrB;
        tick();
        upd_valid = 1'b0; upd_mispred = 1'b0;
    endtask

    task automatic resetPulse();
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
    endtask

    initial begin
        RSTn = 1'b0; lk_pc = '0; upd_pc = '0; upd_target = '0; upd_valid = 1'b0;
        upd_is_jump = 1'b0; upd_taken = 1'b0; upd_mispred = 1'b0;
        updGhrA = 1'b0; updGhrB = '0;
        tick(); tick();
        chkEn = 1'b1;
        RSTn  = 1'b1;

        look(12'h040);
        check("rst_hit", 32'(lkHit[0]), 32'd0);
        check("rst_taken", 32'(lkTaken[0]), 32'd0);
        check("rst_target", 32'(lkTarget[0]), 32'h044);
        check("rst_stat_hits", statHits[0], 32'd0);

        doUpd(12'h040, 1'b0, 1'b1, 12'h010, 1'b0);
        look(12'h040);
        check("alloc_hit", 32'(lkHit[0]), 32'd1);
        check("alloc_taken", 32'(lkTaken[0]), 32'd1);
        check("alloc_target", 32'(lkTarget[0]), 32'h010);
        doUpd(12'h040, 1'b0, 1'b0, 12'h010, 1'b0);
        doUpd(12'h040, 1'b0, 1'b0, 12'h010, 1'b0);
        look(12'h040);
        check("nt2_hit", 32'(lkHit[0]), 32'd1);
        check("nt2_taken", 32'(lkTaken[0]), 32'd0);

        repeat (5) doUpd(12'h040, 1'b0, 1'b1, 12'h010, 1'b0);
        doUpd(12'h040, 1'b0, 1'b0, 12'h010, 1'b0);
        look(12'h040);
        check("sat_taken", 32'(lkTaken[0]), 32'd1);
        doUpd(12'h040, 1'b0, 1'b0, 12'h010, 1'b0);
        look(12'h040);
        check("sat_nt", 32'(lkTaken[0]), 32'd0);

        doUpd(12'h080, 1'b0, 1'b1, 12'h0A0, 1'b0);
        look(12'h040);
        check("alias_old_hit", 32'(lkHit[0]), 32'd0);
        look(12'h080);
        check("alias_new_hit", 32'(lkHit[0]), 32'd1);
        check("alias_new_target", 32'(lkTarget[0]), 32'h0A0);

        resetPulse();
        doUpd(12'h100, 1'b1, 1'b1, 12'h200, 1'b0);
        look(12'h100);
        check("jal_taken", 32'(lkTaken[0]), 32'd1);
        check("jal_target", 32'(lkTarget[0]), 32'h200);
        check("jal_ghr", 32'(lkGhrB), 32'd0);
        doUpd(12'h040, 1'b0, 1'b1, 12'h010, 1'b0);
        doUpd(12'h040, 1'b0, 1'b0, 12'h010, 1'b0);
        check("ghr_tn", 32'(lkGhrB), 32'b0010);

        lk_pc = 12'h0C0;
        upd_valid = 1'b1; upd_pc = 12'h0C0; upd_is_jump = 1'b0; upd_taken = 1'b1;
        upd_target = 12'h030; updGhrB = lkGhrB;
        #1;
        check("rbw_pre_hit", 32'(lkHit[0]), 32'd0);
        tick();
        upd_valid = 1'b0;
        #1;
        check("rbw_post_hit", 32'(lkHit[0]), 32'd1);
        check("rbw_post_target", 32'(lkTarget[0]), 32'h030);

        repeat (3) doUpd(12'h300, 1'b0, 1'b0, 12'h000, 1'b1);
        look(12'h0C0);
        check("mispred_cnt", statMisp[0], 32'd3);
        RSTn = 1'b0;
        upd_valid = 1'b1; upd_pc = 12'h340; upd_is_jump = 1'b0; upd_taken = 1'b1;
        upd_mispred = 1'b1; upd_target = 12'h123;
        tick();
        RSTn = 1'b1;
        look(12'h0C0);
        check("midrst_hit", 32'(lkHit[0]), 32'd0);
        check("midrst_mispred", statMisp[0], 32'd0);
        look(12'h340);
        check("midrst_upd_ignored", 32'(lkHit[0]), 32'd0);
        upd_mispred = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            RSTn        = ($urandom_range(0, 199) != 0);
            lk_pc       = 12'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
            upd_valid   = ($urandom_range(0, 2) != 0);
            upd_pc      = 12'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
            upd_is_jump = ($urandom_range(0, 3) == 0);
            upd_taken   = upd_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
            upd_target  = 12'($urandom_range(0, 4095));
            upd_mispred = 1'($urandom_range(0, 1));
            updGhrB     = 4'($urandom_range(0, 15));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
